// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and parallel byte output bundle of uart_rx
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver with mid-bit sampling
module uart_rx #(
  parameter int BAUD = 9600,
  parameter int F    = 50000000
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);
  localparam int DIV  = (F + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          busy_q;

  assign rx_s          = sync_q[1];
  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      rx_d        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.rx};
      rx_d        <= rx_s;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          cnt    <= '0;
          // Edge, not level: a line stuck low after a break never restarts a frame
          if (!rx_s && rx_d) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            // Returning here, mid stop bit, lets a start edge follow with no idle gap
            if (rx_s) begin
              data_q  <= shift;
              valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at DIV=16
module tb_uart_rx;
  localparam int F      = 160;
  localparam int BAUD   = 10;
  localparam int DIV    = 16;
  localparam int HALF   = 8;
  localparam int T_CLK  = 10;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  uart_rx_if u_if();

  uart_rx #(.BAUD(BAUD), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  exp_t       exp_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         cyc          = 0;
  int         fall_cyc     = 0;
  int         last_strobe_cyc = 0;
  int         strobe_cnt   = 0;
  logic [7:0] held         = 8'h00;

  initial clk = 1'b0;
  always #(T_CLK / 2) clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.valid && u_if.frame_err) begin
        tests_run++;
        tests_failed++;
        $display("FAIL strobe_exclusive: valid=%b frame_err=%b, required not both", u_if.valid, u_if.frame_err);
      end
      if (u_if.valid || u_if.frame_err) begin
        exp_t e;
        tests_run++;
        strobe_cnt++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%h, required no strobe", u_if.valid, u_if.frame_err, u_if.data);
        end else begin
          e = exp_q.pop_front();
          if (u_if.frame_err !== e.is_err || u_if.valid !== !e.is_err ||
              (!e.is_err && u_if.data !== e.data) || (e.is_err && u_if.data !== held)) begin
            tests_failed++;
            $display("FAIL scoreboard: valid=%b frame_err=%b data=%h, required frame_err=%b data=%h",
                     u_if.valid, u_if.frame_err, u_if.data, e.is_err, e.is_err ? held : e.data);
          end
          if (!e.is_err) held = e.data;
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int period_t, input logic stop_val, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.is_err = !stop_val;
      e.data   = b;
      exp_q.push_back(e);
    end
    fall_cyc = cyc;
    u_if.rx = 1'b0;
    #(period_t);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      #(period_t);
    end
    u_if.rx = stop_val;
    #(period_t);
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || u_if.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 2000) begin
      tests_failed++;
      $display("FAIL %s_timeout: pending=%0d busy=%b, required drained and idle", name, exp_q.size(), u_if.busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (u_if.data !== 8'h00 || u_if.valid !== 1'b0 || u_if.frame_err !== 1'b0 || u_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: data=%h valid=%b frame_err=%b busy=%b, required 00 0 0 0",
               u_if.data, u_if.valid, u_if.frame_err, u_if.busy);
    end
    align();
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int s0 = strobe_cnt;
    int lat;
    align();
    fork
      send_frame(8'hA5, DIV * T_CLK, 1'b1, 1'b1);
      begin
        repeat (20) @(negedge clk);
        tests_run++;
        if (u_if.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_busy_early: busy=%b, required 1", u_if.busy);
        end
        repeat (130) @(negedge clk);
        tests_run++;
        if (u_if.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_busy_late: busy=%b, required 1", u_if.busy);
        end
      end
    join
    wait_idle("single");
    tests_run++;
    if (strobe_cnt - s0 !== 1 || u_if.data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_result: strobes=%0d data=%h, required 1 a5", strobe_cnt - s0, u_if.data);
    end
    lat = last_strobe_cyc - fall_cyc;
    tests_run++;
    if (lat < HALF + 9 * DIV + 2 || lat > HALF + 9 * DIV + 5) begin
      tests_failed++;
      $display("FAIL single_latency: %0d cycles, required %0d..%0d", lat, HALF + 9 * DIV + 2, HALF + 9 * DIV + 5);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = strobe_cnt;
    align();
    send_frame(8'h00, DIV * T_CLK, 1'b1, 1'b1);
    send_frame(8'hFF, DIV * T_CLK, 1'b1, 1'b1);
    send_frame(8'h55, DIV * T_CLK, 1'b1, 1'b1);
    wait_idle("b2b");
    tests_run++;
    if (strobe_cnt - s0 !== 3 || u_if.data !== 8'h55) begin
      tests_failed++;
      $display("FAIL b2b_result: strobes=%0d data=%h, required 3 55", strobe_cnt - s0, u_if.data);
    end
  endtask

  task automatic test_glitch();
    int  s0 = strobe_cnt;
    bit  saw_busy = 1'b0;
    align();
    u_if.rx = 1'b0;
    fork
      begin
        #(4 * T_CLK);
        u_if.rx = 1'b1;
      end
      for (int i = 0; i < HALF + 4; i++) begin
        @(negedge clk);
        if (u_if.busy) saw_busy = 1'b1;
      end
    join
    tests_run++;
    if (saw_busy !== 1'b1 || u_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_busy: saw_busy=%b busy_now=%b, required 1 0", saw_busy, u_if.busy);
    end
    repeat (2 * DIV) @(negedge clk);
    tests_run++;
    if (strobe_cnt !== s0 || u_if.data !== 8'h55) begin
      tests_failed++;
      $display("FAIL glitch_quiet: strobes=%0d data=%h, required 0 55", strobe_cnt - s0, u_if.data);
    end
  endtask

  task automatic test_frame_err();
    align();
    send_frame(8'h12, DIV * T_CLK, 1'b1, 1'b1);
    send_frame(8'h3C, DIV * T_CLK, 1'b0, 1'b1);
    #(40 * T_CLK);
    tests_run++;
    if (u_if.busy !== 1'b0 || u_if.data !== 8'h12) begin
      tests_failed++;
      $display("FAIL break_idle: busy=%b data=%h, required 0 12", u_if.busy, u_if.data);
    end
    u_if.rx = 1'b1;
    #(DIV * T_CLK);
    align();
    send_frame(8'h7E, DIV * T_CLK, 1'b1, 1'b1);
    wait_idle("frame_err");
    tests_run++;
    if (u_if.data !== 8'h7E) begin
      tests_failed++;
      $display("FAIL after_break: data=%h, required 7e", u_if.data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    align();
    fork
      send_frame(8'hC3, DIV * T_CLK, 1'b1, 1'b0);
      begin
        #(88 * T_CLK);
        tests_run++;
        if (u_if.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL midframe_busy: busy=%b, required 1", u_if.busy);
        end
        rst = 1'b1;
        #1;
        held = 8'h00;
        tests_run++;
        if (u_if.data !== 8'h00 || u_if.valid !== 1'b0 || u_if.frame_err !== 1'b0 || u_if.busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL midframe_reset: data=%h valid=%b frame_err=%b busy=%b, required 00 0 0 0",
                   u_if.data, u_if.valid, u_if.frame_err, u_if.busy);
        end
        #(28 * T_CLK);
        rst = 1'b0;
      end
    join
    s0 = strobe_cnt;
    #(2 * DIV * T_CLK);
    align();
    send_frame(8'h81, DIV * T_CLK, 1'b1, 1'b1);
    wait_idle("post_reset");
    tests_run++;
    if (strobe_cnt - s0 !== 1 || u_if.data !== 8'h81) begin
      tests_failed++;
      $display("FAIL post_reset: strobes=%0d data=%h, required 1 81", strobe_cnt - s0, u_if.data);
    end
  endtask

  task automatic test_baud_tolerance();
    int periods[2] = '{155, 170};
    for (int p = 0; p < 2; p++) begin
      int s0 = strobe_cnt;
      align();
      send_frame(8'h96, periods[p], 1'b1, 1'b1);
      wait_idle("baud");
      tests_run++;
      if (strobe_cnt - s0 !== 1 || u_if.data !== 8'h96) begin
        tests_failed++;
        $display("FAIL baud_%0d: strobes=%0d data=%h, required 1 96", periods[p], strobe_cnt - s0, u_if.data);
      end
      #(2 * DIV * T_CLK);
    end
  endtask

  initial begin
    rst = 1'b1;
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_baud_tolerance();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover_expected: %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #(200000 * T_CLK);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
